lcd_status_sequencer: RTL and testbench

//  Game-status front end for the character-LCD writer. Its lcd_msg output drives the writer's
//  4-bit Din message-select input. Turns one-cycle game event pulses into counters and messages:
//  hit/miss pulses update a 4-digit BCD score and a lives counter, and the block selects the

---
 rtl/lcd_status_sequencer.sv | 166 ++++++++++++++++
 tb/tb_lcd_status_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_status_sequencer.sv
// lcd_status_sequencer
//   Game-status front end for the character-LCD writer. It turns one-cycle game
//   event pulses into a 4-digit BCD score, a lives counter, and a banner code
//   for the writer's message-select input. Transient banners are held for
//   HOLD_CYCLES clocks so the LCD refresh loop has time to show them.
//
// Parameters
//   HOLD_CYCLES  clocks a transient banner stays asserted (>= 1)
//   LIVES_INIT   lives loaded on game start (1..3)
//
// Ports
//   clk_1MHz   in   1   system clock
//   rst        in   1   synchronous, active-high reset
//   start_btn  in   1   one-cycle pulse: start/restart a game
//   hit_evt    in   1   one-cycle pulse: player scored
//   miss_evt   in   1   one-cycle pulse: player lost a life
//   lcd_msg    out  4   0000 none/keep, 0001 fail banner, 0010 ok banner
//   score_bcd  out 16   packed BCD score, [15:12] most significant digit
//   lives      out  2   remaining lives
//   game_over  out  1   high while the game is over
module lcd_status_sequencer #(
  parameter int HOLD_CYCLES = 500000,
  parameter int LIVES_INIT  = 3
) (
  input  logic        clk_1MHz,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        hit_evt,
  input  logic        miss_evt,
  output logic [3:0]  lcd_msg,
  output logic [15:0] score_bcd,
  output logic [1:0]  lives,
  output logic        game_over
);

  // A one-cycle hold still needs a 1-bit timer to keep the vector legal.
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [1:0]    LIVES_START = 2'(LIVES_INIT);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PLAY      = 3'd1;
  localparam logic [2:0] ST_SHOW_OK   = 3'd2;
  localparam logic [2:0] ST_SHOW_FAIL = 3'd3;
  localparam logic [2:0] ST_OVER      = 3'd4;

  localparam logic [3:0] MSG_NONE = 4'b0000;
  localparam logic [3:0] MSG_FAIL = 4'b0001;
  localparam logic [3:0] MSG_OK   = 4'b0010;

  // BCD +1 with per-digit ripple carry; 9999 saturates instead of wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      r = v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] >= 4'd9) begin
            r[i*4 +: 4] = 4'd0;
            carry       = 1'b1;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [2:0]    state_r;
  logic [TW-1:0] timer_r;

  logic [2:0]    state_s;
  logic [TW-1:0] timer_s;
  logic [15:0]   score_s;
  logic [1:0]    lives_s;
  logic [3:0]    msg_s;
  logic          over_s;

  // Next-state, counter and banner selection.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    score_s = score_bcd;
    lives_s = lives;
    case (state_r)
      ST_IDLE, ST_OVER: begin
        if (start_btn) begin
          state_s = ST_PLAY;
          timer_s = '0;
          score_s = 16'h0000;
          lives_s = LIVES_START;
        end else begin
          state_s = state_r;
        end
      end
      ST_PLAY, ST_SHOW_OK, ST_SHOW_FAIL: begin
        // A miss takes priority over a simultaneous hit.
        if (miss_evt) begin
          timer_s = '0;
          if (lives > 2'd1) begin
            lives_s = lives - 2'd1;
            state_s = ST_SHOW_FAIL;
          end else begin
            lives_s = 2'd0;
            state_s = ST_OVER;
          end
        end else if (hit_evt) begin
          score_s = bcd_inc(score_bcd);
          state_s = ST_SHOW_OK;
          timer_s = '0;
        end else if (state_r != ST_PLAY) begin
          if (timer_r == TIMER_LAST) begin
            state_s = ST_PLAY;
            timer_s = '0;
          end else begin
            timer_s = timer_r + TW'(1);
          end
        end else begin
          state_s = ST_PLAY;
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = '0;
        score_s = 16'h0000;
        lives_s = 2'd0;
      end
    endcase

    case (state_s)
      ST_SHOW_OK:   msg_s = MSG_OK;
      ST_SHOW_FAIL: msg_s = MSG_FAIL;
      ST_OVER:      msg_s = MSG_FAIL;
      default:      msg_s = MSG_NONE;
    endcase
    over_s = (state_s == ST_OVER);
  end

  // State, timer and all outputs registered together.
  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      timer_r   <= '0;
      lcd_msg   <= MSG_NONE;
      score_bcd <= 16'h0000;
      lives     <= 2'd0;
      game_over <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      lcd_msg   <= msg_s;
      score_bcd <= score_s;
      lives     <= lives_s;
      game_over <= over_s;
    end
  end

endmodule

// File: tb/tb_lcd_status_sequencer.sv
// tb_lcd_status_sequencer
//   Self-checking bench: a behavioural game model (integer score, lives count,
//   banner countdown) is compared against the DUT on every falling edge, while
//   directed sequences pin the model and DUT to hand-computed values, followed
//   by a randomized event phase.
module tb_lcd_status_sequencer;

  localparam int HOLD = 8;
  localparam int LI   = 3;

  logic        clk_1MHz = 1'b0;
  logic        rst = 1'b0, start_btn = 1'b0, hit_evt = 1'b0, miss_evt = 1'b0;
  logic [3:0]  lcd_msg;
  logic [15:0] score_bcd;
  logic [1:0]  lives;
  logic        game_over;

  int n_cmp = 0;
  int n_err = 0;

  lcd_status_sequencer #(.HOLD_CYCLES(HOLD), .LIVES_INIT(LI)) dut (
    .clk_1MHz (clk_1MHz),
    .rst      (rst),
    .start_btn(start_btn),
    .hit_evt  (hit_evt),
    .miss_evt (miss_evt),
    .lcd_msg  (lcd_msg),
    .score_bcd(score_bcd),
    .lives    (lives),
    .game_over(game_over)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  // Behavioural model: game in progress or not, decimal score, banner countdown.
  int m_score = 0, m_lives = 0, m_left = 0, m_banner = 0;
  bit m_play = 1'b0, m_over = 1'b0, m_valid = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] exp_msg();
    if (m_over) return 4'd1;
    if (m_left > 0) return 4'(m_banner);
    return 4'd0;
  endfunction

  always @(posedge clk_1MHz) begin
    if (rst) begin
      m_play = 1'b0; m_over = 1'b0; m_score = 0; m_lives = 0;
      m_left = 0; m_banner = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (!m_play) begin
        if (start_btn) begin
          m_play = 1'b1; m_over = 1'b0; m_score = 0; m_lives = LI; m_left = 0;
        end
      end else if (miss_evt) begin
        if (m_lives > 1) begin
          m_lives = m_lives - 1; m_banner = 1; m_left = HOLD;
        end else begin
          m_lives = 0; m_play = 1'b0; m_over = 1'b1; m_left = 0;
        end
      end else if (hit_evt) begin
        if (m_score < 9999) m_score = m_score + 1;
        m_banner = 2; m_left = HOLD;
      end else if (m_left > 0) begin
        m_left = m_left - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk_1MHz) begin
    if (m_valid) begin
      chk("lcd_msg",   {12'd0, lcd_msg},   {12'd0, exp_msg()});
      chk("score_bcd", score_bcd,          to_bcd(m_score));
      chk("lives",     {14'd0, lives},     16'(m_lives));
      chk("game_over", {15'd0, game_over}, {15'd0, m_over});
    end
  end

  task automatic step(input logic r, input logic s, input logic h, input logic m);
    rst = r; start_btn = s; hit_evt = h; miss_evt = m;
    @(posedge clk_1MHz);
    #1;
    rst = 1'b0; start_btn = 1'b0; hit_evt = 1'b0; miss_evt = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_msg", {12'd0, lcd_msg}, 16'd0);
    chk("rst_score", score_bcd, 16'h0000);
    chk("rst_lives", {14'd0, lives}, 16'd0);
    chk("rst_over", {15'd0, game_over}, 16'd0);

    // Start, then one hit: banner exactly HOLD cycles.
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_lives", {14'd0, lives}, 16'd3);
    chk("start_score", score_bcd, 16'h0000);
    chk("start_msg", {12'd0, lcd_msg}, 16'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("hit_score", score_bcd, 16'h0001);
    chk("hit_msg", {12'd0, lcd_msg}, 16'd2);
    idle(HOLD - 1);
    chk("hold_last", {12'd0, lcd_msg}, 16'd2);
    idle(1);
    chk("hold_end", {12'd0, lcd_msg}, 16'd0);

    // Reset mid SHOW_OK.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst2_msg", {12'd0, lcd_msg}, 16'd0);
    chk("rst2_score", score_bcd, 16'h0000);
    chk("rst2_lives", {14'd0, lives}, 16'd0);
    idle(2);
    chk("rst2_idle_msg", {12'd0, lcd_msg}, 16'd0);

    // Hit and miss together: miss wins.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("both_lives", {14'd0, lives}, 16'd2);
    chk("both_score", score_bcd, 16'h0000);
    chk("both_msg", {12'd0, lcd_msg}, 16'd1);

    // Lose the remaining lives, over state holds, hits ignored, restart.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("miss_lives1", {14'd0, lives}, 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("over_lives", {14'd0, lives}, 16'd0);
    chk("over_flag", {15'd0, game_over}, 16'd1);
    idle(3 * HOLD);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("over_msg_held", {12'd0, lcd_msg}, 16'd1);
    chk("over_hit_ignored", score_bcd, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("restart_lives", {14'd0, lives}, 16'd3);
    chk("restart_over", {15'd0, game_over}, 16'd0);
    chk("restart_msg", {12'd0, lcd_msg}, 16'd0);

    // Second hit 3 cycles into SHOW_OK restarts the hold.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rehit_score", score_bcd, 16'h0002);
    idle(HOLD - 1);
    chk("rehit_hold_last", {12'd0, lcd_msg}, 16'd2);
    idle(1);
    chk("rehit_hold_end", {12'd0, lcd_msg}, 16'd0);

    // BCD carry across digits, then saturation at 9999.
    for (int i = 0; i < 97; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("score_0099", score_bcd, 16'h0099);
    chk("model_0099", to_bcd(m_score), 16'h0099);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("score_0100", score_bcd, 16'h0100);
    for (int i = 0; i < 9899; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("score_9999", score_bcd, 16'h9999);
    idle(HOLD + 2);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sat_score", score_bcd, 16'h9999);
    chk("sat_msg", {12'd0, lcd_msg}, 16'd2);
    chk("model_sat", to_bcd(m_score), 16'h9999);

    // Randomized events checked by the per-cycle model comparison.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      step(r == 0, (r >= 1) && (r <= 6),
           $urandom_range(0, 9) < 2, $urandom_range(0, 24) == 0);
    end

    @(negedge clk_1MHz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
